// File: rtl/load_scoreboard.sv
// Load scoreboard: tracks destination registers of in-flight loads and stalls hazardous issue.
// Optional macro LOAD_SB_CSR_SERIALIZE_EN holds CSR ops until all loads have drained.
module load_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1),
  localparam int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic              issue_rs1_read_i,
  input  logic [REG_AW-1:0] issue_rs1_addr_i,
  input  logic              issue_rs2_read_i,
  input  logic [REG_AW-1:0] issue_rs2_addr_i,
  input  logic              issue_rd_write_i,
  input  logic [REG_AW-1:0] issue_rd_addr_i,
  input  logic              issue_mem_read_i,
  input  logic              issue_csr_i,
  input  logic              issue_ready_ext_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  output logic              sb_stall_o,
  output logic              issue_go_o,
  output logic [31:0]       sb_pending_o,
  output logic [CNT_W-1:0]  sb_count_o,
  output logic              sb_empty_o,
  output logic              sb_err_o
);

  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic raw1, raw2, waw, full, csr_hold;
  logic load_go, wb_hit, wb_x0, cnt_dec;

  // Hazards look only at registered state; a same-cycle writeback is not bypassed.
  assign raw1 = issue_rs1_read_i & pending_q[issue_rs1_addr_i];
  assign raw2 = issue_rs2_read_i & pending_q[issue_rs2_addr_i];
  assign waw  = issue_rd_write_i & pending_q[issue_rd_addr_i];
  assign full = issue_mem_read_i & (count_q == CNT_W'(MAX_OUTSTANDING));

`ifdef LOAD_SB_CSR_SERIALIZE_EN
  assign csr_hold = issue_csr_i & (count_q != '0);
`else
  assign csr_hold = 1'b0;
`endif

  assign sb_stall_o = issue_valid_i & (raw1 | raw2 | waw | full | csr_hold);
  assign issue_go_o = issue_valid_i & ~sb_stall_o & issue_ready_ext_i;

  assign load_go = issue_go_o & issue_mem_read_i;
  assign wb_hit  = wb_valid_i & pending_q[wb_addr_i];
  assign wb_x0   = wb_valid_i & (wb_addr_i == '0);
  // x0 loads leave no bitmap trace, so their writeback only retires a count.
  assign cnt_dec = (wb_hit | wb_x0) & (count_q != '0);

  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    err_d     = err_q;
    if (wb_hit) begin
      pending_d[wb_addr_i] = 1'b0;
    end
    if (load_go && issue_rd_write_i) begin
      pending_d[issue_rd_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
    if (load_go && !cnt_dec) begin
      count_d = count_q + CNT_W'(1);
    end else if (!load_go && cnt_dec) begin
      count_d = count_q - CNT_W'(1);
    end
    if (wb_valid_i && !wb_hit && !cnt_dec) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign sb_pending_o = pending_q;
  assign sb_count_o   = count_q;
  assign sb_empty_o   = (count_q == '0);
  assign sb_err_o     = err_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed table-driven bench for load_scoreboard (MAX_OUTSTANDING = 2).
module tb_load_scoreboard;

  logic        clk, rst;
  logic        valid, r1, r2, w, m, c, rdy, wbv;
  logic [4:0]  a1, a2, ad, wba;
  logic        stall, go, empty, err;
  logic [31:0] pend;
  logic [1:0]  cnt;

  int checks = 0;
  int failures = 0;

  load_scoreboard #(.MAX_OUTSTANDING(2)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .issue_valid_i    (valid),
    .issue_rs1_read_i (r1),
    .issue_rs1_addr_i (a1),
    .issue_rs2_read_i (r2),
    .issue_rs2_addr_i (a2),
    .issue_rd_write_i (w),
    .issue_rd_addr_i  (ad),
    .issue_mem_read_i (m),
    .issue_csr_i      (c),
    .issue_ready_ext_i(rdy),
    .wb_valid_i       (wbv),
    .wb_addr_i        (wba),
    .sb_stall_o       (stall),
    .issue_go_o       (go),
    .sb_pending_o     (pend),
    .sb_count_o       (cnt),
    .sb_empty_o       (empty),
    .sb_err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v, r1, r2, w, m, c, rdy, wbv;
    logic [4:0] a1, a2, ad, wba;
    logic e_stall, e_go;
    logic [31:0] e_pend;
    logic [1:0] e_cnt;
    logic e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic r1_, logic [4:0] a1_, logic r2_, logic [4:0] a2_,
                              logic w_, logic [4:0] ad_, logic m_, logic rdy_, logic wbv_,
                              logic [4:0] wba_, logic es, logic eg, logic [31:0] ep,
                              logic [1:0] ec, logic ee);
    vec_t x;
    x.v = v; x.r1 = r1_; x.a1 = a1_; x.r2 = r2_; x.a2 = a2_; x.w = w_; x.ad = ad_;
    x.m = m_; x.c = 1'b0; x.rdy = rdy_; x.wbv = wbv_; x.wba = wba_;
    x.e_stall = es; x.e_go = eg; x.e_pend = ep; x.e_cnt = ec; x.e_err = ee;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid = 0; r1 = 0; r2 = 0; w = 0; m = 0; c = 0; rdy = 1; wbv = 0;
    a1 = 0; a2 = 0; ad = 0; wba = 0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] ep, input logic [1:0] ec,
                             input logic ee);
    chk({tag, ".pending"}, pend, ep);
    chk({tag, ".count"}, 32'(cnt), 32'(ec));
    chk({tag, ".empty"}, 32'(empty), 32'(ec == 2'd0));
    chk({tag, ".err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    check_state("reset", 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    //        v r1 a1 r2 a2 w ad m rdy wbv wba  stall go pend  cnt err
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 1, 1, 0, 0, 0, 1, 32'h0,   0, 0)); // load x5
    vecs.push_back(mk(1, 1, 5, 0, 0, 1, 6, 0, 1, 0, 0, 1, 0, 32'h20,  1, 0)); // raw x5
    vecs.push_back(mk(1, 1, 5, 0, 0, 1, 6, 0, 1, 0, 0, 1, 0, 32'h20,  1, 0));
    vecs.push_back(mk(1, 1, 5, 0, 0, 1, 6, 0, 1, 1, 5, 1, 0, 32'h20,  1, 0)); // wb x5, no bypass
    vecs.push_back(mk(1, 1, 5, 0, 0, 1, 6, 0, 1, 0, 0, 0, 1, 32'h0,   0, 0)); // released
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 32'h0,   0, 0)); // load x0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,   1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0,   1, 0)); // wb x0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 32'h0,   0, 0)); // load x1
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0, 0, 1, 32'h2,   1, 0)); // load x2
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 1, 1, 1, 1, 0, 32'h6,   2, 0)); // full, wb x1
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 1, 0, 0, 0, 1, 32'h4,   1, 0)); // x3 issues
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hC,   2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 1, 0, 32'hC,   2, 0)); // full, not ready
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 32'hC,   2, 0)); // wb x2
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 32'h8,   1, 0)); // ready low
    vecs.push_back(mk(1, 0, 0, 1, 3, 1, 7, 0, 1, 1, 3, 1, 0, 32'h8,   1, 0)); // raw rs2 x3
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9, 1, 1, 0, 0, 0, 1, 32'h0,   0, 0)); // load x9
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 1, 0, 0, 1, 0, 32'h200, 1, 0)); // waw x9
    vecs.push_back(mk(1, 0, 9, 0, 9, 1,10, 0, 1, 0, 0, 0, 1, 32'h200, 1, 0)); // reads disabled
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0, 32'h200, 1, 0)); // wb x9
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 32'h0,   0, 0)); // stray wb x7
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,   0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,   0, 1)); // err sticky

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      valid = vecs[i].v; r1 = vecs[i].r1; a1 = vecs[i].a1; r2 = vecs[i].r2; a2 = vecs[i].a2;
      w = vecs[i].w; ad = vecs[i].ad; m = vecs[i].m; c = vecs[i].c; rdy = vecs[i].rdy;
      wbv = vecs[i].wbv; wba = vecs[i].wba;
      #1;
      chk({tag, ".stall"}, 32'(stall), 32'(vecs[i].e_stall));
      chk({tag, ".go"}, 32'(go), 32'(vecs[i].e_go));
      check_state(tag, vecs[i].e_pend, vecs[i].e_cnt, vecs[i].e_err);
      @(negedge clk);
    end

    // Async reset mid-operation with two loads pending.
    idle_inputs();
    valid = 1; w = 1; ad = 1; m = 1;
    @(negedge clk);
    ad = 2;
    @(negedge clk);
    idle_inputs();
    #1;
    check_state("pre_rst", 32'h6, 2'd2, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_state("mid_rst", 32'h0, 2'd0, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);

    // CSR while x4 pending.
    idle_inputs();
    valid = 1; w = 1; ad = 4; m = 1;
    @(negedge clk);
    idle_inputs();
    valid = 1; c = 1; w = 1; ad = 6;
    #1;
`ifdef LOAD_SB_CSR_SERIALIZE_EN
    chk("csr_held.stall", 32'(stall), 32'd1);
    chk("csr_held.go", 32'(go), 32'd0);
`else
    chk("csr_free.stall", 32'(stall), 32'd0);
    chk("csr_free.go", 32'(go), 32'd1);
`endif
    @(negedge clk);
    wbv = 1; wba = 4;
    #1;
`ifdef LOAD_SB_CSR_SERIALIZE_EN
    chk("csr_wb.go", 32'(go), 32'd0);
`else
    chk("csr_wb.go", 32'(go), 32'd1);
`endif
    @(negedge clk);
    wbv = 0; wba = 0;
    #1;
    chk("csr_drained.stall", 32'(stall), 32'd0);
    chk("csr_drained.go", 32'(go), 32'd1);
    check_state("csr_drained", 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
